// File: rtl/vram_arbiter.sv
// Shares one single-port VRAM between the scan-out fetch and two round-robin writers.
// Optional VRAM_ARBITER_BLANK_ONLY_EN restricts writes to blanking cycles so the display never tears.
module vram_arbiter #(
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int SCALE_LOG2 = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pix_stb,
    input  logic        i_active,
    input  logic [9:0]  i_x,
    input  logic [8:0]  i_y,
    input  logic [1:0]  i_req,
    input  logic [14:0] i_waddr0,
    input  logic [14:0] i_waddr1,
    input  logic [7:0]  i_wdata0,
    input  logic [7:0]  i_wdata1,
    output logic [1:0]  o_gnt,
    output logic        o_err,
    output logic [14:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [7:0]  o_mem_wdata,
    input  logic [7:0]  i_mem_rdata,
    output logic [7:0]  o_pix,
    output logic        o_pix_valid
);

    localparam logic [9:0]  SUB_MASK = 10'((1 << SCALE_LOG2) - 1);
    localparam int unsigned TEX_CNT  = FB_W * FB_H;

    logic        fetch;
    logic        wslot;
    logic        grant;
    logic        sel;
    logic        oor;
    logic        ptr;
    logic        rd_pend;
    logic [14:0] fetch_addr;
    logic [14:0] sel_addr;

    assign fetch_addr = 15'(15'(i_y >> SCALE_LOG2) * 15'(FB_W)) + 15'(i_x >> SCALE_LOG2);
    assign fetch      = i_pix_stb & i_active & ((i_x & SUB_MASK) == 10'd0) & ~i_rst;

`ifdef VRAM_ARBITER_BLANK_ONLY_EN
    assign wslot = ~fetch & ~i_active & ~i_rst;
`else
    assign wslot = ~fetch & ~i_rst;
`endif

    // With a single requester the pointer is ignored; it only breaks ties.
    assign sel      = (i_req == 2'b11) ? ptr : i_req[1];
    assign grant    = wslot & (i_req != 2'b00);
    assign sel_addr = sel ? i_waddr1 : i_waddr0;
    assign oor      = 32'(sel_addr) >= TEX_CNT;

    always_comb begin
        o_gnt       = 2'b00;
        o_err       = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = sel_addr;
        o_mem_wdata = sel ? i_wdata1 : i_wdata0;
        if (fetch) begin
            o_mem_addr = fetch_addr;
        end else if (grant) begin
            o_gnt    = sel ? 2'b10 : 2'b01;
            o_err    = oor;
            o_mem_we = ~oor;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_pix       <= 8'd0;
            o_pix_valid <= 1'b0;
            ptr         <= 1'b0;
            rd_pend     <= 1'b0;
        end else begin
            rd_pend <= fetch;
            // Read data from last cycle's fetch takes precedence over a blanking clear.
            if (rd_pend) begin
                o_pix       <= i_mem_rdata;
                o_pix_valid <= 1'b1;
            end else if (i_pix_stb && !i_active) begin
                o_pix       <= 8'd0;
                o_pix_valid <= 1'b0;
            end
            if (grant) begin
                ptr <= ~sel;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed and randomized checks of vram_arbiter against a cycle-level behavioural model.
module tb_vram_arbiter;

`ifdef VRAM_ARBITER_BLANK_ONLY_EN
    localparam bit BLANK_ONLY = 1'b1;
`else
    localparam bit BLANK_ONLY = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_pix_stb = 1'b0;
    logic        i_active = 1'b0;
    logic [9:0]  i_x = '0;
    logic [8:0]  i_y = '0;
    logic [1:0]  i_req = '0;
    logic [14:0] i_waddr0 = '0;
    logic [14:0] i_waddr1 = '0;
    logic [7:0]  i_wdata0 = '0;
    logic [7:0]  i_wdata1 = '0;
    logic [7:0]  i_mem_rdata = '0;
    logic [1:0]  o_gnt;
    logic        o_err;
    logic [14:0] o_mem_addr;
    logic        o_mem_we;
    logic [7:0]  o_mem_wdata;
    logic [7:0]  o_pix;
    logic        o_pix_valid;

    int checks = 0;
    int failures = 0;

    // behavioural model state
    int         m_ptr = 0;
    logic [7:0] m_pix = 8'd0;
    logic       m_valid = 1'b0;
    bit         m_pend = 1'b0;

    // expectations for the current cycle
    bit         e_fetch;
    int         e_srv;
    logic [1:0] e_gnt;
    logic       e_we;
    logic       e_err;
    int         e_addr;
    logic [7:0] e_wdata;

    vram_arbiter dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb), .i_active(i_active),
        .i_x(i_x), .i_y(i_y), .i_req(i_req),
        .i_waddr0(i_waddr0), .i_waddr1(i_waddr1),
        .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
        .o_gnt(o_gnt), .o_err(o_err), .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
        .o_pix(o_pix), .o_pix_valid(o_pix_valid)
    );

    always #5 i_clk = ~i_clk;

    task automatic model_comb();
        bit slot;
        int waddr;
        e_fetch = !i_rst && i_pix_stb && i_active && (int'(i_x) % 4 == 0);
        slot    = !i_rst && !e_fetch && (!BLANK_ONLY || !i_active);
        e_srv   = -1;
        if (slot && i_req != 2'b00) begin
            if (i_req == 2'b11) e_srv = m_ptr;
            else                e_srv = i_req[1] ? 1 : 0;
        end
        waddr   = (e_srv == 1) ? int'(i_waddr1) : int'(i_waddr0);
        e_wdata = (e_srv == 1) ? i_wdata1 : i_wdata0;
        e_gnt   = (e_srv < 0) ? 2'b00 : ((e_srv == 1) ? 2'b10 : 2'b01);
        e_err   = (e_srv >= 0) && (waddr >= 160 * 120);
        e_we    = (e_srv >= 0) && (waddr < 160 * 120);
        e_addr  = e_fetch ? (int'(i_y) / 4) * 160 + int'(i_x) / 4 : waddr;
    endtask

    // Clock one edge and move the model along with the inputs held during that cycle.
    task automatic advance();
        model_comb();
        @(posedge i_clk);
        if (i_rst) begin
            m_pix = 8'd0; m_valid = 1'b0; m_pend = 1'b0; m_ptr = 0;
        end else begin
            if (m_pend) begin
                m_pix = i_mem_rdata; m_valid = 1'b1;
            end else if (i_pix_stb && !i_active) begin
                m_pix = 8'd0; m_valid = 1'b0;
            end
            m_pend = e_fetch;
            if (e_srv >= 0) m_ptr = 1 - e_srv;
        end
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        advance();
        i_rst = 1'b0;
    endtask

    task automatic idle_inputs();
        i_pix_stb = 1'b0; i_active = 1'b0; i_req = 2'b00; i_x = '0; i_y = '0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_req = 2'b11; i_pix_stb = 1'b1; i_active = 1'b1; i_x = '0;
        for (int i = 0; i < 2; i++) begin
            #4;
            checks++;
            if (o_gnt !== 2'b00 || o_mem_we !== 1'b0 || o_err !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs gnt=%b we=%b err=%b required 00/0/0", o_gnt, o_mem_we, o_err);
            end
            advance();
        end
        i_rst = 1'b0;
        idle_inputs();
        checks++;
        if (o_pix !== 8'h00 || o_pix_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_pix pix=%h valid=%b required 00/0", o_pix, o_pix_valid);
        end
    endtask

    task automatic test_fetch();
        i_active = 1'b1; i_pix_stb = 1'b1; i_x = 10'd8; i_y = 9'd4; i_req = 2'b00;
        #4;
        checks++;
        if (o_mem_addr !== 15'd162 || o_mem_we !== 1'b0) begin
            failures++;
            $display("FAIL fetch_addr addr=%0d we=%b required 162/0", o_mem_addr, o_mem_we);
        end
        advance();
        i_x = 10'd9; i_mem_rdata = 8'hE3;
        #4;
        advance();
        checks++;
        if (o_pix !== 8'hE3 || o_pix_valid !== 1'b1) begin
            failures++;
            $display("FAIL fetch_latch pix=%h valid=%b required e3/1", o_pix, o_pix_valid);
        end
        for (int x = 10; x <= 11; x++) begin
            i_x = 10'(x); i_mem_rdata = 8'h11;
            #4;
            checks++;
            if (o_mem_we !== 1'b0) begin
                failures++;
                $display("FAIL fetch_hold_we x=%0d we=%b required 0", x, o_mem_we);
            end
            advance();
            checks++;
            if (o_pix !== 8'hE3 || o_pix_valid !== 1'b1) begin
                failures++;
                $display("FAIL fetch_hold x=%0d pix=%h valid=%b required e3/1", x, o_pix, o_pix_valid);
            end
        end
        idle_inputs();
    endtask

    task automatic test_round_robin();
        logic [1:0] seq [4];
        seq = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        idle_inputs();
        i_req = 2'b11; i_waddr0 = 15'd100; i_waddr1 = 15'd200; i_wdata0 = 8'h12; i_wdata1 = 8'h34;
        for (int i = 0; i < 4; i++) begin
            #4;
            checks++;
            if (o_gnt !== seq[i] || o_mem_we !== 1'b1 ||
                o_mem_addr !== (seq[i] == 2'b01 ? 15'd100 : 15'd200) ||
                o_mem_wdata !== (seq[i] == 2'b01 ? 8'h12 : 8'h34)) begin
                failures++;
                $display("FAIL rr_%0d gnt=%b addr=%0d wdata=%h we=%b required gnt=%b", i,
                         o_gnt, o_mem_addr, o_mem_wdata, o_mem_we, seq[i]);
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_collision();
        i_active = 1'b1; i_pix_stb = 1'b1; i_x = 10'd0; i_y = 9'd8; i_req = 2'b10; i_waddr1 = 15'd300;
        #4;
        checks++;
        if (o_gnt !== 2'b00 || o_mem_addr !== 15'd320 || o_mem_we !== 1'b0) begin
            failures++;
            $display("FAIL collision_fetch gnt=%b addr=%0d we=%b required 00/320/0", o_gnt, o_mem_addr, o_mem_we);
        end
        advance();
        i_pix_stb = 1'b0; i_active = !BLANK_ONLY;
        #4;
        checks++;
        if (o_gnt !== 2'b10 || o_mem_addr !== 15'd300 || o_mem_we !== 1'b1) begin
            failures++;
            $display("FAIL collision_next gnt=%b addr=%0d we=%b required 10/300/1", o_gnt, o_mem_addr, o_mem_we);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_range();
        i_req = 2'b01; i_waddr0 = 15'd19200;
        #4;
        checks++;
        if (o_gnt !== 2'b01 || o_err !== 1'b1 || o_mem_we !== 1'b0) begin
            failures++;
            $display("FAIL range_over gnt=%b err=%b we=%b required 01/1/0", o_gnt, o_err, o_mem_we);
        end
        advance();
        i_waddr0 = 15'd19199;
        #4;
        checks++;
        if (o_gnt !== 2'b01 || o_err !== 1'b0 || o_mem_we !== 1'b1 || o_mem_addr !== 15'd19199) begin
            failures++;
            $display("FAIL range_edge gnt=%b err=%b we=%b addr=%0d required 01/0/1/19199",
                     o_gnt, o_err, o_mem_we, o_mem_addr);
        end
        advance();
        i_req = 2'b00;
        #4;
        checks++;
        if (o_err !== 1'b0 || o_gnt !== 2'b00 || o_mem_we !== 1'b0) begin
            failures++;
            $display("FAIL range_idle err=%b gnt=%b we=%b required 0/00/0", o_err, o_gnt, o_mem_we);
        end
        advance();
    endtask

    task automatic test_blank_only();
        i_active = 1'b1; i_pix_stb = 1'b1; i_x = 10'd1; i_req = 2'b01; i_waddr0 = 15'd5;
        #4;
        checks++;
        if (o_gnt !== (BLANK_ONLY ? 2'b00 : 2'b01)) begin
            failures++;
            $display("FAIL blank_active gnt=%b required %b", o_gnt, BLANK_ONLY ? 2'b00 : 2'b01);
        end
        advance();
        i_active = 1'b0;
        #4;
        checks++;
        if (o_gnt !== 2'b01) begin
            failures++;
            $display("FAIL blank_inactive gnt=%b required 01", o_gnt);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_reset_midstream();
        i_req = 2'b01; i_waddr0 = 15'd10;
        advance();
        i_req = 2'b00; i_active = 1'b1; i_pix_stb = 1'b1; i_x = 10'd0; i_y = 9'd0;
        advance();
        i_pix_stb = 1'b0; i_mem_rdata = 8'hAA;
        advance();
        checks++;
        if (o_pix !== 8'hAA || o_pix_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre pix=%h valid=%b required aa/1", o_pix, o_pix_valid);
        end
        i_rst = 1'b1; i_pix_stb = 1'b1; i_x = 10'd4; i_req = 2'b11;
        #4;
        checks++;
        if (o_gnt !== 2'b00 || o_mem_we !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst gnt=%b we=%b required 00/0", o_gnt, o_mem_we);
        end
        advance();
        i_rst = 1'b0; i_pix_stb = 1'b0; i_req = 2'b00; i_mem_rdata = 8'h55;
        advance();
        checks++;
        if (o_pix !== 8'h00 || o_pix_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_discard pix=%h valid=%b required 00/0", o_pix, o_pix_valid);
        end
        i_active = 1'b0; i_req = 2'b11;
        #4;
        checks++;
        if (o_gnt !== 2'b01) begin
            failures++;
            $display("FAIL mid_ptr gnt=%b required 01", o_gnt);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_random();
        int served;
        do_reset();
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            i_rst       = ($urandom_range(0, 39) == 0);
            i_pix_stb   = ($urandom_range(0, 3) != 0);
            i_active    = ($urandom_range(0, 4) != 0);
            i_x         = 10'($urandom_range(0, 639));
            i_y         = 9'($urandom_range(0, 479));
            i_mem_rdata = 8'($urandom);
            for (int w = 0; w < 2; w++) begin
                if (!i_req[w] && $urandom_range(0, 2) == 0) begin
                    logic [14:0] a;
                    a = ($urandom_range(0, 7) == 0) ? 15'($urandom_range(19200, 32767))
                                                    : 15'($urandom_range(0, 19199));
                    i_req[w] = 1'b1;
                    if (w == 0) begin i_waddr0 = a; i_wdata0 = 8'($urandom); end
                    else        begin i_waddr1 = a; i_wdata1 = 8'($urandom); end
                end
            end
            #4;
            model_comb();
            served = e_srv;
            checks++;
            if (o_gnt !== e_gnt || o_mem_we !== e_we || o_err !== e_err) begin
                failures++;
                $display("FAIL rnd_ctrl cyc=%0d gnt=%b we=%b err=%b required %b/%b/%b",
                         c, o_gnt, o_mem_we, o_err, e_gnt, e_we, e_err);
            end
            if (e_fetch || e_srv >= 0) begin
                checks++;
                if (int'(o_mem_addr) != e_addr) begin
                    failures++;
                    $display("FAIL rnd_addr cyc=%0d addr=%0d required %0d", c, o_mem_addr, e_addr);
                end
            end
            if (e_we) begin
                checks++;
                if (o_mem_wdata !== e_wdata) begin
                    failures++;
                    $display("FAIL rnd_wdata cyc=%0d wdata=%h required %h", c, o_mem_wdata, e_wdata);
                end
            end
            advance();
            checks++;
            if (o_pix !== m_pix || o_pix_valid !== m_valid) begin
                failures++;
                $display("FAIL rnd_pix cyc=%0d pix=%h valid=%b required %h/%b", c, o_pix, o_pix_valid, m_pix, m_valid);
            end
            if (served >= 0 && $urandom_range(0, 1) == 0) i_req[served] = 1'b0;
        end
        i_rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        @(posedge i_clk);
        #1;
        test_reset();
        test_fetch();
        test_round_robin();
        test_collision();
        test_range();
        test_blank_only();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
